// File: rtl/history_scanner.sv
// history_scanner: sweeps a raster of read addresses over a colour history
// store and issues write-backs. Pen paint requests are written with priority.
// During decay frames every nonzero pixel read back is written one step lower.
module history_scanner #(
  parameter int H_MAX        = 640,
  parameter int V_MAX        = 480,
  parameter int DECAY_PERIOD = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pen_valid,
  input  logic [9:0] pen_x,
  input  logic [9:0] pen_y,
  input  logic [3:0] pen_color,
  output logic       pen_ready,
  input  logic       decay_enable,
  output logic [9:0] read_x,
  output logic [9:0] read_y,
  input  logic [3:0] read_data,
  input  logic       data_valid,
  input  logic [9:0] just_read_x,
  input  logic [9:0] just_read_y,
  output logic [9:0] write_x,
  output logic [9:0] write_y,
  output logic [3:0] write_data,
  output logic       write_en,
  output logic       frame_done
);

  localparam logic [9:0]  X_LAST  = 10'(H_MAX - 1);
  localparam logic [9:0]  Y_LAST  = 10'(V_MAX - 1);
  localparam logic [15:0] FC_LAST = 16'(DECAY_PERIOD - 1);

  logic [9:0]  read_x_q, read_y_q;
  logic        frame_done_q;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        decay_frame_q, decay_frame_d;
  logic        armed_q;
  logic        pend_valid_q;
  logic [9:0]  pend_x_q, pend_y_q;
  logic [3:0]  pend_color_q;
  logic [9:0]  write_x_q, write_y_q;
  logic [3:0]  write_data_q;
  logic        write_en_q;
  logic        wrap;
  logic        decay_hit;
  logic        pen_accept;

  assign wrap       = (read_x_q == X_LAST) && (read_y_q == Y_LAST);
  assign pen_ready  = armed_q && !pend_valid_q;
  assign pen_accept = pen_valid && pen_ready;
  assign decay_hit  = decay_frame_q && data_valid && (read_data != '0);

  // Next frame counter and the decay flag that will hold for the coming frame
  always_comb begin
    frame_cnt_d   = frame_cnt_q;
    decay_frame_d = decay_frame_q;
    if (wrap) begin
      frame_cnt_d   = (frame_cnt_q == FC_LAST) ? '0 : frame_cnt_q + 16'd1;
      decay_frame_d = (frame_cnt_d == FC_LAST) && decay_enable;
    end
  end

  // Raster address generator, frame pulse and frame bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_x_q      <= '0;
      read_y_q      <= '0;
      frame_done_q  <= 1'b0;
      frame_cnt_q   <= '0;
      decay_frame_q <= 1'b0;
    end else begin
      frame_done_q  <= wrap;
      frame_cnt_q   <= frame_cnt_d;
      decay_frame_q <= decay_frame_d;
      if (read_y_q == Y_LAST) begin
        read_y_q <= '0;
        read_x_q <= (read_x_q == X_LAST) ? '0 : read_x_q + 10'd1;
      end else begin
        read_y_q <= read_y_q + 10'd1;
      end
    end
  end

  // Arm once the history store reports valid data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) armed_q <= 1'b0;
    else if (data_valid) armed_q <= 1'b1;
  end

  // Pen request capture and write port; a pending pen write beats a decay write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_valid_q <= 1'b0;
      pend_x_q     <= '0;
      pend_y_q     <= '0;
      pend_color_q <= '0;
      write_x_q    <= '0;
      write_y_q    <= '0;
      write_data_q <= '0;
      write_en_q   <= 1'b0;
    end else begin
      write_en_q <= 1'b0;
      if (pen_accept) begin
        pend_valid_q <= 1'b1;
        pend_x_q     <= pen_x;
        pend_y_q     <= pen_y;
        pend_color_q <= pen_color;
      end
      if (pend_valid_q) begin
        pend_valid_q <= 1'b0;
        write_x_q    <= pend_x_q;
        write_y_q    <= pend_y_q;
        write_data_q <= pend_color_q;
        write_en_q   <= 1'b1;
      end else if (decay_hit) begin
        write_x_q    <= just_read_x;
        write_y_q    <= just_read_y;
        write_data_q <= read_data - 4'd1;
        write_en_q   <= 1'b1;
      end
    end
  end

  assign read_x     = read_x_q;
  assign read_y     = read_y_q;
  assign frame_done = frame_done_q;
  assign write_x    = write_x_q;
  assign write_y    = write_y_q;
  assign write_data = write_data_q;
  assign write_en   = write_en_q;

endmodule

// File: tb/tb_history_scanner.sv
// Directed bench for history_scanner on a small 4x3 raster, decay every 2nd frame.
module tb_history_scanner;

  localparam int H = 4;
  localparam int V = 3;
  localparam int DP = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pen_valid = 1'b0;
  logic [9:0] pen_x = '0, pen_y = '0;
  logic [3:0] pen_color = '0;
  logic       pen_ready;
  logic       decay_enable = 1'b0;
  logic [9:0] read_x, read_y;
  logic [3:0] read_data = '0;
  logic       data_valid = 1'b0;
  logic [9:0] just_read_x = '0, just_read_y = '0;
  logic [9:0] write_x, write_y;
  logic [3:0] write_data;
  logic       write_en;
  logic       frame_done;

  int vectors = 0;
  int miscompares = 0;

  history_scanner #(.H_MAX(H), .V_MAX(V), .DECAY_PERIOD(DP)) dut (
    .clk(clk), .reset(reset),
    .pen_valid(pen_valid), .pen_x(pen_x), .pen_y(pen_y), .pen_color(pen_color),
    .pen_ready(pen_ready), .decay_enable(decay_enable),
    .read_x(read_x), .read_y(read_y), .read_data(read_data), .data_valid(data_valid),
    .just_read_x(just_read_x), .just_read_y(just_read_y),
    .write_x(write_x), .write_y(write_y), .write_data(write_data),
    .write_en(write_en), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
  endtask

  // Reset across one posedge; returns at the negedge where reset is released (k=0)
  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1;
    pen_valid = 1'b0; data_valid = 1'b0; decay_enable = 1'b0;
    read_data = '0; just_read_x = '0; just_read_y = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b1;
    #1;
    vectors++;
    if ({read_x, read_y, write_x, write_y, write_data, write_en, frame_done, pen_ready} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got rx=%0d ry=%0d wx=%0d wy=%0d wd=%0d we=%b fd=%b pr=%b, want all 0",
               read_x, read_y, write_x, write_y, write_data, write_en, frame_done, pen_ready);
    end
  endtask

  task automatic test_unarmed;
    do_reset();
    pen_valid = 1'b1; pen_x = 10'd1; pen_y = 10'd1; pen_color = 4'd1;
    for (int i = 0; i < 6; i++) begin
      tick();
      vectors++;
      if (pen_ready !== 1'b0 || write_en !== 1'b0) begin
        miscompares++;
        $display("FAIL unarmed c%0d: pen_ready=%b write_en=%b, want 0 0", i, pen_ready, write_en);
      end
    end
    pen_valid = 1'b0;
  endtask

  task automatic test_raster;
    int ex, ey;
    logic efd;
    do_reset();
    for (int k = 0; k < 30; k++) begin
      ex = (k / V) % H;
      ey = k % V;
      efd = (k != 0) && (k % (H * V) == 0);
      vectors++;
      if (read_x !== 10'(ex) || read_y !== 10'(ey) || frame_done !== efd) begin
        miscompares++;
        $display("FAIL raster k=%0d: got (%0d,%0d) fd=%b, want (%0d,%0d) fd=%b",
                 k, read_x, read_y, frame_done, ex, ey, efd);
      end
      tick();
    end
  endtask

  task automatic test_pen_write;
    do_reset();
    data_valid = 1'b1;
    vectors++;
    if (pen_ready !== 1'b0) begin
      miscompares++; $display("FAIL pen_not_yet_armed: pen_ready=%b want 0", pen_ready);
    end
    tick();
    vectors++;
    if (pen_ready !== 1'b1) begin
      miscompares++; $display("FAIL pen_armed: pen_ready=%b want 1", pen_ready);
    end
    pen_valid = 1'b1; pen_x = 10'd5; pen_y = 10'd7; pen_color = 4'd9;
    tick();
    pen_valid = 1'b0;
    vectors++;
    if (pen_ready !== 1'b0 || write_en !== 1'b0) begin
      miscompares++; $display("FAIL pen_pending: pen_ready=%b write_en=%b want 0 0", pen_ready, write_en);
    end
    tick();
    vectors++;
    if (write_en !== 1'b1 || write_x !== 10'd5 || write_y !== 10'd7 || write_data !== 4'd9 || pen_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL pen_write: we=%b (%0d,%0d,%0d) pr=%b, want 1 (5,7,9) 1",
               write_en, write_x, write_y, write_data, pen_ready);
    end
    tick();
    vectors++;
    if (write_en !== 1'b0 || write_x !== 10'd5 || write_data !== 4'd9) begin
      miscompares++;
      $display("FAIL pen_hold: we=%b wx=%0d wd=%0d, want 0 5 9", write_en, write_x, write_data);
    end
  endtask

  task automatic test_back_to_back;
    pen_valid = 1'b1; pen_x = 10'd1; pen_y = 10'd2; pen_color = 4'd3;
    tick();
    pen_x = 10'd1000; pen_y = 10'd900; pen_color = 4'd15;
    vectors++;
    if (pen_ready !== 1'b0 || write_en !== 1'b0) begin
      miscompares++; $display("FAIL b2b_accept1: pr=%b we=%b want 0 0", pen_ready, write_en);
    end
    tick();
    vectors++;
    if (write_en !== 1'b1 || write_x !== 10'd1 || write_y !== 10'd2 || write_data !== 4'd3 || pen_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_write1: we=%b (%0d,%0d,%0d) pr=%b want 1 (1,2,3) 1",
               write_en, write_x, write_y, write_data, pen_ready);
    end
    tick();
    pen_valid = 1'b0;
    vectors++;
    if (write_en !== 1'b0 || pen_ready !== 1'b0) begin
      miscompares++; $display("FAIL b2b_accept2: we=%b pr=%b want 0 0", write_en, pen_ready);
    end
    tick();
    vectors++;
    if (write_en !== 1'b1 || write_x !== 10'd1000 || write_y !== 10'd900 || write_data !== 4'd15) begin
      miscompares++;
      $display("FAIL b2b_noclip: we=%b (%0d,%0d,%0d) want 1 (1000,900,15)", write_en, write_x, write_y, write_data);
    end
  endtask

  task automatic test_decay;
    do_reset();
    decay_enable = 1'b1; data_valid = 1'b1;
    repeat (10) tick();                      // k=10, normal frame
    read_data = 4'd5; just_read_x = 10'd1; just_read_y = 10'd1;
    tick();                                  // k=11
    vectors++;
    if (write_en !== 1'b0) begin
      miscompares++; $display("FAIL decay_off_frame0: write_en=%b want 0", write_en);
    end
    tick();                                  // k=12, decay frame
    read_data = 4'd3; just_read_x = 10'd10; just_read_y = 10'd20;
    tick();                                  // k=13
    vectors++;
    if (write_en !== 1'b1 || write_x !== 10'd10 || write_y !== 10'd20 || write_data !== 4'd2) begin
      miscompares++;
      $display("FAIL decay_write: we=%b (%0d,%0d,%0d) want 1 (10,20,2)", write_en, write_x, write_y, write_data);
    end
    read_data = 4'd1; just_read_x = 10'd11;
    tick();                                  // k=14
    vectors++;
    if (write_en !== 1'b1 || write_x !== 10'd11 || write_data !== 4'd0) begin
      miscompares++; $display("FAIL decay_to_zero: we=%b wx=%0d wd=%0d want 1 11 0", write_en, write_x, write_data);
    end
    read_data = 4'd0; just_read_x = 10'd12;
    tick();                                  // k=15
    vectors++;
    if (write_en !== 1'b0 || write_x !== 10'd11 || write_data !== 4'd0) begin
      miscompares++; $display("FAIL decay_saturate: we=%b wx=%0d wd=%0d want 0 11 0", write_en, write_x, write_data);
    end
    read_data = 4'd4; data_valid = 1'b0;
    tick();                                  // k=16
    vectors++;
    if (write_en !== 1'b0) begin
      miscompares++; $display("FAIL decay_invalid: write_en=%b want 0", write_en);
    end
    data_valid = 1'b1; read_data = 4'd0;
    repeat (9) tick();                       // k=25, non-decay frame
    read_data = 4'd5;
    tick();                                  // k=26
    vectors++;
    if (write_en !== 1'b0) begin
      miscompares++; $display("FAIL decay_off_frame2: write_en=%b want 0", write_en);
    end
    read_data = 4'd0;
  endtask

  task automatic test_collision;
    do_reset();
    decay_enable = 1'b1; data_valid = 1'b1;
    repeat (12) tick();                      // k=12, decay frame, armed
    pen_valid = 1'b1; pen_x = 10'd7; pen_y = 10'd8; pen_color = 4'd4;
    tick();                                  // k=13, pend_valid set
    pen_valid = 1'b0;
    read_data = 4'd6; just_read_x = 10'd2; just_read_y = 10'd2;
    tick();                                  // k=14
    vectors++;
    if (write_en !== 1'b1 || write_x !== 10'd7 || write_y !== 10'd8 || write_data !== 4'd4) begin
      miscompares++;
      $display("FAIL collision_pen_wins: we=%b (%0d,%0d,%0d) want 1 (7,8,4)", write_en, write_x, write_y, write_data);
    end
    just_read_x = 10'd3; just_read_y = 10'd3;
    tick();                                  // k=15
    vectors++;
    if (write_en !== 1'b1 || write_x !== 10'd3 || write_y !== 10'd3 || write_data !== 4'd5) begin
      miscompares++;
      $display("FAIL collision_next_decay: we=%b (%0d,%0d,%0d) want 1 (3,3,5)", write_en, write_x, write_y, write_data);
    end
    read_data = 4'd0;
  endtask

  task automatic test_reset_pending;
    do_reset();
    data_valid = 1'b1;
    tick();
    pen_valid = 1'b1; pen_x = 10'd5; pen_y = 10'd7; pen_color = 4'd9;
    tick();
    pen_valid = 1'b0;
    tick();                                  // write (5,7,9) visible
    pen_valid = 1'b1; pen_x = 10'd9; pen_y = 10'd9; pen_color = 4'd2;
    tick();                                  // second request pending
    pen_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if ({read_x, read_y, write_x, write_y, write_data, write_en, frame_done, pen_ready} !== '0) begin
      miscompares++;
      $display("FAIL reset_async: got rx=%0d ry=%0d wx=%0d wy=%0d wd=%0d we=%b fd=%b pr=%b, want all 0",
               read_x, read_y, write_x, write_y, write_data, write_en, frame_done, pen_ready);
    end
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (write_en !== 1'b0) begin
        miscompares++; $display("FAIL reset_discard c%0d: write_en=%b want 0", i, write_en);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unarmed();
    test_raster();
    test_pen_write();
    test_back_to_back();
    test_decay();
    test_collision();
    test_reset_pending();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
